std_dev_ctrl: RTL

//  Sequencer for the std_dev datapath. Collects N_INPUT samples from a valid/ready

---
 rtl/std_dev_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/std_dev_ctrl.sv
// Purpose : sequencer for the std_dev datapath; gathers a frame of N_INPUT samples,
//           computes their truncated mean, holds operands for LATENCY cycles and
//           returns {mean, std_dev}.
// Latency : last sample accepted at edge T -> m_valid_o rises at edge T+1+LATENCY.
// Backpr. : s_ready_o only in FILL; result held stable in DONE until m_ready_i.
// Ports   : clk_i/reset_i (sync, active-high); s_valid_i/s_data_i/s_ready_o sample
//           stream; abort_i frame discard; dp_in_data_o/dp_mean_o/dp_std_dev_i to the
//           std_dev datapath; m_valid_o/m_mean_o/m_std_dev_o/m_ready_i result port;
//           busy_o high whenever a frame is in progress or a result is pending.
module std_dev_ctrl #(
   parameter int N_INPUT = 8,
   parameter int SIZE    = 32,
   parameter int LATENCY = 4
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic                      s_valid_i,
   input  logic [SIZE-1:0]           s_data_i,
   output logic                      s_ready_o,
   input  logic                      abort_i,
   output logic [N_INPUT*SIZE-1:0]   dp_in_data_o,
   output logic [SIZE-1:0]           dp_mean_o,
   input  logic [SIZE-1:0]           dp_std_dev_i,
   output logic                      m_valid_o,
   output logic [SIZE-1:0]           m_mean_o,
   output logic [SIZE-1:0]           m_std_dev_o,
   input  logic                      m_ready_i,
   output logic                      busy_o
);

   localparam int CW = $clog2(N_INPUT);
   localparam int SW = SIZE + CW;                           // sum cannot overflow
   localparam int WW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {FILL, MEAN, RUN, DONE} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q;
   logic [SW-1:0]     sum_q;
   logic [SIZE-1:0]   smp_q [N_INPUT];
   logic [SIZE-1:0]   dp_mean_q;
   logic [WW-1:0]     wcnt_q;
   logic              m_valid_q;
   logic [SIZE-1:0]   m_mean_q;
   logic [SIZE-1:0]   m_std_q;

   logic accept;
   logic last_smp;
   logic wait_done;

   // A sample offered together with abort is dropped.
   assign accept    = (state_q == FILL) && s_valid_i && !abort_i;
   assign last_smp  = (cnt_q == CW'(N_INPUT - 1));
   assign wait_done = (wcnt_q == WW'(LATENCY - 1));

   // State register
   always_ff @(posedge clk_i) begin
      if (reset_i) state_q <= FILL;
      else         state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         FILL: if (accept && last_smp) state_d = MEAN;
         MEAN: state_d = abort_i ? FILL : RUN;
         RUN:  if (abort_i)        state_d = FILL;
               else if (wait_done) state_d = DONE;
         DONE: if (m_ready_i)      state_d = FILL;   // abort ignored here
         default: state_d = FILL;
      endcase
   end

   // Outputs depend on registered state only, never on s_valid_i/m_ready_i.
   always_comb begin
      s_ready_o = (state_q == FILL);
      busy_o    = !((state_q == FILL) && (cnt_q == '0));
   end

   // Datapath registers
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt_q     <= '0;
         sum_q     <= '0;
         dp_mean_q <= '0;
         wcnt_q    <= '0;
         m_valid_q <= 1'b0;
         m_mean_q  <= '0;
         m_std_q   <= '0;
         for (int k = 0; k < N_INPUT; k++) smp_q[k] <= '0;
      end else begin
         if (accept) begin
            smp_q[cnt_q] <= s_data_i;
            sum_q        <= sum_q + SW'(s_data_i);
            cnt_q        <= last_smp ? '0 : cnt_q + CW'(1);
         end
         if (abort_i && (state_q != DONE)) begin
            cnt_q <= '0;
            sum_q <= '0;
         end
         if ((state_q == MEAN) && !abort_i) begin
            dp_mean_q <= SIZE'(sum_q >> CW);
            wcnt_q    <= '0;
         end
         if ((state_q == RUN) && !abort_i) begin
            wcnt_q <= wcnt_q + WW'(1);
            if (wait_done) begin
               m_std_q   <= dp_std_dev_i;
               m_mean_q  <= dp_mean_q;
               m_valid_q <= 1'b1;
            end
         end
         if ((state_q == DONE) && m_ready_i) begin
            m_valid_q <= 1'b0;
            sum_q     <= '0;
            cnt_q     <= '0;
         end
      end
   end

   // Sample 0 lands in the most significant slice.
   for (genvar k = 0; k < N_INPUT; k++) begin : g_pack
      assign dp_in_data_o[(N_INPUT-k)*SIZE-1 -: SIZE] = smp_q[k];
   end

   assign dp_mean_o   = dp_mean_q;
   assign m_valid_o   = m_valid_q;
   assign m_mean_o    = m_mean_q;
   assign m_std_dev_o = m_std_q;

endmodule
